// File: rtl/rng_pkg.sv
// Shared types and constants for the pipe-gap random source.
// Pure declarations: no latency, no flow control.
package rng_pkg;

  typedef enum logic {IDLE, DRAW} fsm_t;

  localparam logic [15:0] LFSR16_TAPS = 16'hB400;
  localparam logic [15:0] LFSR16_SEED = 16'hACE1;

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Free-running Galois LFSR with seed load, entropy stirring and zero-state guard.
// Latency: one edge for every update. Backpressure: none, steps every cycle.
module lfsr_core
  import rng_pkg::*;
#(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR16_TAPS,
  parameter logic [LFSR_W-1:0] SEED   = LFSR16_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic [9:0]        entropy_in,
  input  logic              entropy_valid,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] stepped;
  logic [LFSR_W-1:0] mixed;
  logic [LFSR_W-1:0] state_d;

  // Every branch falls back to SEED on zero so the register can never lock up.
  always_comb begin
    stepped = (state >> 1) ^ (state[0] ? TAPS : '0);
    mixed   = stepped ^ LFSR_W'(entropy_in);
    state_d = (stepped == '0) ? SEED : stepped;
    if (seed_load) begin
      state_d = (seed_in == '0) ? SEED : seed_in;
    end else if (entropy_valid) begin
      state_d = (mixed == '0) ? SEED : mixed;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else begin
      state <= state_d;
    end
  end

endmodule

// File: rtl/pipe_gap_rng.sv
// Bounded random value source for pipe gaps; req -> rand_valid in 2..MAX_TRIES+1 edges.
// Backpressure: req is ignored while busy and not remembered.
module pipe_gap_rng
  import rng_pkg::*;
#(
  parameter int                LFSR_W    = 16,
  parameter int                OUT_W     = 4,
  parameter logic [LFSR_W-1:0] TAPS      = LFSR16_TAPS,
  parameter logic [LFSR_W-1:0] SEED      = LFSR16_SEED,
  parameter int                RANGE_MIN = 0,
  parameter int                RANGE_MAX = 15,
  parameter int                MAX_TRIES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic [9:0]        entropy_in,
  input  logic              entropy_valid,
  input  logic              req,
  output logic [OUT_W-1:0]  rand_out,
  output logic              rand_valid,
  output logic              busy
);

  if (LFSR_W < 10 || OUT_W > LFSR_W || SEED == '0 || MAX_TRIES < 1 ||
      RANGE_MIN < 0 || RANGE_MIN > RANGE_MAX || RANGE_MAX >= (1 << OUT_W)) begin : g_param_check
    $error("pipe_gap_rng: illegal parameter combination");
  end

  localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  logic [LFSR_W-1:0] state;
  fsm_t              fsm_q, fsm_d;
  logic [TRY_W-1:0]  tries_q, tries_d;
  logic [OUT_W-1:0]  out_d;
  logic              vld_d;
  int                cand_i;
  int                clamped;

  lfsr_core #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS),
    .SEED   (SEED)
  ) u_lfsr (
    .clk           (clk),
    .rst           (rst),
    .seed_load     (seed_load),
    .seed_in       (seed_in),
    .entropy_in    (entropy_in),
    .entropy_valid (entropy_valid),
    .state         (state)
  );

  // A candidate is in range exactly when clamping leaves it unchanged.
  always_comb begin
    fsm_d   = fsm_q;
    tries_d = tries_q;
    out_d   = rand_out;
    vld_d   = 1'b0;
    cand_i  = int'(state[OUT_W-1:0]);
    clamped = clamp(cand_i, RANGE_MIN, RANGE_MAX);
    case (fsm_q)
      IDLE: begin
        if (req) begin
          fsm_d   = DRAW;
          tries_d = '0;
        end
      end
      DRAW: begin
        if (clamped == cand_i || tries_q == TRY_W'(MAX_TRIES - 1)) begin
          out_d = OUT_W'(clamped);
          vld_d = 1'b1;
          fsm_d = IDLE;
        end else begin
          tries_d = tries_q + 1'b1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q      <= IDLE;
      tries_q    <= '0;
      rand_out   <= OUT_W'(RANGE_MIN);
      rand_valid <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      tries_q    <= tries_d;
      rand_out   <= out_d;
      rand_valid <= vld_d;
    end
  end

  assign busy = (fsm_q == DRAW);

endmodule

// File: tb/tb_pipe_gap_rng.sv
// Directed bench for pipe_gap_rng: three configurations share one stimulus stream
// and are checked every cycle against a reference model feeding a scoreboard.
module tb_pipe_gap_rng;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed_in = '0;
  logic [9:0]  entropy_in = '0;
  logic        entropy_valid = 1'b0;
  logic [2:0]  req = '0;
  logic [3:0]  r_out [3];
  logic        r_vld [3];
  logic        r_busy [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_gap_rng dut_a (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
    .entropy_in(entropy_in), .entropy_valid(entropy_valid), .req(req[0]),
    .rand_out(r_out[0]), .rand_valid(r_vld[0]), .busy(r_busy[0])
  );

  pipe_gap_rng #(.RANGE_MIN(3), .RANGE_MAX(12)) dut_b (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
    .entropy_in(entropy_in), .entropy_valid(entropy_valid), .req(req[1]),
    .rand_out(r_out[1]), .rand_valid(r_vld[1]), .busy(r_busy[1])
  );

  pipe_gap_rng #(.RANGE_MIN(5), .RANGE_MAX(5), .MAX_TRIES(2)) dut_c (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
    .entropy_in(entropy_in), .entropy_valid(entropy_valid), .req(req[2]),
    .rand_out(r_out[2]), .rand_valid(r_vld[2]), .busy(r_busy[2])
  );

  localparam int MN [3] = '{0, 3, 5};
  localparam int MX [3] = '{15, 12, 5};
  localparam int MT [3] = '{8, 8, 2};

  logic [15:0] m_state, m_nx;
  logic        m_busy [3];
  int          m_tries [3];
  logic [3:0]  m_out [3];
  logic        m_vld [3];
  int          m_c, m_v;
  int          sb [$];
  int          dcount [3] = '{0, 0, 0};
  bit          chk_en = 1'b0;

  function automatic logic [15:0] f_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: advances on the same edge as the DUTs, pushes each expected delivery.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 16'hACE1;
      for (int i = 0; i < 3; i++) begin
        m_busy[i] = 1'b0; m_tries[i] = 0; m_out[i] = 4'(MN[i]); m_vld[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_vld[i] = 1'b0;
        if (!m_busy[i]) begin
          if (req[i]) begin m_busy[i] = 1'b1; m_tries[i] = 0; end
        end else begin
          m_c = int'(m_state[3:0]);
          m_v = -1;
          if (m_c >= MN[i] && m_c <= MX[i]) m_v = m_c;
          else if (m_tries[i] == MT[i] - 1) m_v = (m_c < MN[i]) ? MN[i] : MX[i];
          else m_tries[i]++;
          if (m_v >= 0) begin
            m_out[i] = 4'(m_v); m_vld[i] = 1'b1; m_busy[i] = 1'b0;
            sb.push_back(i * 256 + m_v);
          end
        end
      end
      if (seed_load) m_state = (seed_in == 16'h0) ? 16'hACE1 : seed_in;
      else if (entropy_valid) begin
        m_nx = f_step(m_state) ^ {6'b0, entropy_in};
        m_state = (m_nx == 16'h0) ? 16'hACE1 : m_nx;
      end else m_state = f_step(m_state);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("lfsr_state", dut_a.u_lfsr.state, m_state);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("rand_valid%0d", i), r_vld[i], m_vld[i]);
        chk($sformatf("busy%0d", i), r_busy[i], m_busy[i]);
        chk($sformatf("rand_out%0d", i), r_out[i], m_out[i]);
        if (r_vld[i] === 1'b1) begin
          dcount[i]++;
          chk($sformatf("sb_nonempty%0d", i), sb.size() > 0, 1);
          if (sb.size() > 0) chk($sformatf("sb_value%0d", i), i * 256 + r_out[i], sb.pop_front());
        end
      end
    end
  end

  initial begin
    logic [15:0] tbl [7];
    int lat, base;
    bit got;
    tbl = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C, 16'h1C4E, 16'h0E27, 16'hB313};

    #1 rst = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_state", dut_a.u_lfsr.state, tbl[0]);
    chk("reset_out_b", r_out[1], 4'd3);
    chk("reset_vld_a", r_vld[0], 1'b0);
    for (int i = 1; i < 7; i++) begin
      @(negedge clk);
      chk($sformatf("free_run%0d", i), dut_a.u_lfsr.state, tbl[i]);
    end

    // Seed loads, including the zero seed and an entropy mix that lands on zero.
    @(posedge clk); #1 seed_load = 1'b1; seed_in = 16'h0000;
    @(posedge clk); #1 seed_load = 1'b0;
    @(negedge clk); chk("seed_zero", dut_a.u_lfsr.state, 16'hACE1);
    seed_load = 1'b1; seed_in = 16'h0004;
    @(posedge clk); #1 seed_load = 1'b0;
    chk("seed_load", dut_a.u_lfsr.state, 16'h0004);
    entropy_valid = 1'b1; entropy_in = 10'h002;
    @(posedge clk); #1 entropy_valid = 1'b0;
    chk("mix_zero", dut_a.u_lfsr.state, 16'hACE1);

    // Back-to-back deliveries with req held high.
    @(negedge clk);
    base = dcount[0];
    req[0] = 1'b1;
    repeat (10) @(posedge clk);
    #1 req[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("b2b_count", dcount[0] - base, 5);

    // Narrow range with entropy stirring, 1000 requests.
    for (int n = 0; n < 1000; n++) begin
      req[1] = 1'b1;
      entropy_valid = 1'($urandom_range(0, 1));
      entropy_in = 10'($urandom);
      @(posedge clk); #1 req[1] = 1'b0; entropy_valid = 1'b0;
      lat = 1; got = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
        @(posedge clk); #1 lat++;
        if (r_vld[1] === 1'b1) got = 1'b1;
      end
      chk("b_delivered", got, 1'b1);
      chk("b_latency_bounds", (lat >= 2 && lat <= 9), 1'b1);
      chk("b_in_range", (r_out[1] >= 4'd3 && r_out[1] <= 4'd12), 1'b1);
    end

    // Both candidates out of range forces the clamp at the last try.
    seed_load = 1'b1; seed_in = 16'h000F; req[2] = 1'b1;
    @(posedge clk); #1 seed_load = 1'b0; req[2] = 1'b0;
    chk("c_seed", dut_a.u_lfsr.state, 16'h000F);
    lat = 1; got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(posedge clk); #1 lat++;
      if (lat == 2) chk("c_step", dut_a.u_lfsr.state, 16'hB407);
      if (r_vld[2] === 1'b1) got = 1'b1;
    end
    chk("c_delivered", got, 1'b1);
    chk("c_clamp_value", r_out[2], 4'd5);
    chk("c_latency", lat, 3);

    // Reset in the middle of a draw, then a normal request.
    req[0] = 1'b1;
    @(posedge clk); #1 req[0] = 1'b0;
    chk("abort_busy_pre", r_busy[0], 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_busy", r_busy[0], 1'b0);
    chk("abort_vld", r_vld[0], 1'b0);
    chk("abort_out", r_out[0], 4'd0);
    chk("abort_state", dut_a.u_lfsr.state, 16'hACE1);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 req[0] = 1'b1;
    @(posedge clk); #1 req[0] = 1'b0;
    lat = 1; got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(posedge clk); #1 lat++;
      if (r_vld[0] === 1'b1) got = 1'b1;
    end
    chk("post_reset_delivered", got, 1'b1);
    chk("post_reset_latency", lat, 2);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
